// File: rtl/gcd_arb_32_if.sv
// Request/response bundle between the requesters/consumer and the gcd_32 arbiter.
// The requester/consumer side is the master; the arbiter is the slave.
interface gcd_arb_32_if #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ-1:0]    req_ready;
  logic               rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        rsp_result;
  logic               rsp_err;
  logic               rsp_ready;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
  );
endinterface

// File: rtl/gcd_arb_32.sv
// Round-robin sequencer sharing one gcd_32 core among NREQ requesters.
// Optional RUN-phase abort is enabled by defining GCD_ARB_TIMEOUT_EN.
module gcd_arb_32 #(
  parameter int NREQ     = 4,
  parameter int LOAD_CYC = 2,
  parameter int TIMEOUT  = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  gcd_arb_32_if.slave bus,
  output logic [31:0] core_ina,
  output logic [31:0] core_inb,
  output logic        core_rst_n,
  input  logic [31:0] core_result,
  input  logic        core_ready_n,
  output logic        busy
);
  localparam int DATA_W = 32;
  localparam int IDW    = $clog2(NREQ);
  localparam int LCW    = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t            state;
  logic [IDW-1:0]    rr_ptr;
  logic [IDW-1:0]    cand;
  logic [IDW-1:0]    gnt_idx;
  logic [IDW-1:0]    ptr_nxt;
  logic              gnt_found;
  logic [NREQ-1:0]   gnt_onehot;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [LCW-1:0]    load_cnt;
  logic              first_run;
  logic              rsp_valid_q;
  logic [IDW-1:0]    rsp_id_q;
  logic [DATA_W-1:0] rsp_result_q;
  logic [DATA_W-1:0] ina_q;
  logic [DATA_W-1:0] inb_q;
  logic              core_rst_q;
  logic              busy_q;

`ifdef GCD_ARB_TIMEOUT_EN
  localparam int RCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [RCW-1:0] run_cnt;
  logic           err_q;
  assign bus.rsp_err = err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  // Grant search starts at rr_ptr and wraps; only offered while IDLE and out of reset.
  always_comb begin
    gnt_found  = 1'b0;
    gnt_idx    = '0;
    cand       = '0;
    gnt_onehot = '0;
    sel_a      = '0;
    sel_b      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    if (state != IDLE || !rst_n) begin
      gnt_found = 1'b0;
    end
    if (gnt_found) begin
      gnt_onehot[gnt_idx] = 1'b1;
    end
    for (int k = 0; k < NREQ; k++) begin
      if (IDW'(k) == gnt_idx) begin
        sel_a = bus.req_a[k*DATA_W +: DATA_W];
        sel_b = bus.req_b[k*DATA_W +: DATA_W];
      end
    end
  end

  assign ptr_nxt = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);

  assign bus.req_ready  = gnt_onehot;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign core_ina       = ina_q;
  assign core_inb       = inb_q;
  assign core_rst_n     = core_rst_q;
  assign busy           = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      load_cnt     <= '0;
      first_run    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      ina_q        <= '0;
      inb_q        <= '0;
      core_rst_q   <= 1'b0;
      busy_q       <= 1'b0;
`ifdef GCD_ARB_TIMEOUT_EN
      run_cnt      <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      case (state)
        // accept: latch operands and owner, advance the round-robin pointer
        IDLE: begin
          if (gnt_found) begin
            ina_q    <= sel_a;
            inb_q    <= sel_b;
            rsp_id_q <= gnt_idx;
            rr_ptr   <= ptr_nxt;
            load_cnt <= '0;
            busy_q   <= 1'b1;
            state    <= LOAD;
          end
        end
        // core held in reset with stable operands for LOAD_CYC cycles
        LOAD: begin
          if (load_cnt == LCW'(LOAD_CYC - 1)) begin
            core_rst_q <= 1'b1;
            first_run  <= 1'b1;
`ifdef GCD_ARB_TIMEOUT_EN
            run_cnt    <= '0;
`endif
            state      <= RUN;
          end else begin
            load_cnt <= load_cnt + LCW'(1);
          end
        end
        // ready_n in the first RUN cycle still reflects the previous job
        RUN: begin
          first_run <= 1'b0;
          if (!first_run && !core_ready_n) begin
            rsp_result_q <= core_result;
            core_rst_q   <= 1'b0;
            rsp_valid_q  <= 1'b1;
            state        <= RESP;
`ifdef GCD_ARB_TIMEOUT_EN
            err_q        <= 1'b0;
          end else if (run_cnt == RCW'(TIMEOUT - 1)) begin
            rsp_result_q <= '0;
            err_q        <= 1'b1;
            core_rst_q   <= 1'b0;
            rsp_valid_q  <= 1'b1;
            state        <= RESP;
          end else begin
            run_cnt <= run_cnt + RCW'(1);
`endif
          end
        end
        // result held until the consumer takes it
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_gcd_arb_32.sv
// Self-checking bench for gcd_arb_32 with a behavioural gcd_32 core model.
module tb_gcd_arb_32;
  localparam int NREQ     = 4;
  localparam int LOAD_CYC = 2;
  localparam int TIMEOUT  = 256;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  gcd_arb_32_if #(.NREQ(NREQ)) bus ();

  logic [31:0] core_ina, core_inb, core_result;
  logic        core_rst_n, core_ready_n, busy;

  gcd_arb_32 #(.NREQ(NREQ), .LOAD_CYC(LOAD_CYC), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .core_ina     (core_ina),
    .core_inb     (core_inb),
    .core_rst_n   (core_rst_n),
    .core_result  (core_result),
    .core_ready_n (core_ready_n),
    .busy         (busy)
  );

  // Core model: Euclid step per cycle; ready_n keeps its old value while held in reset.
  logic [31:0] cx = '0, cy = '0, cres = '0;
  logic        crdy_n = 1'b1;
  logic        stub_hang = 1'b0;
  always @(posedge clk) begin
    if (!core_rst_n) begin
      cx <= core_ina;
      cy <= core_inb;
    end else if (cy == 0) begin
      cres   <= cx;
      crdy_n <= 1'b0;
    end else begin
      cx     <= cy;
      cy     <= cx % cy;
      crdy_n <= 1'b1;
    end
  end
  assign core_result  = cres;
  assign core_ready_n = stub_hang | crdy_n;

  logic [NREQ-1:0] rv = '0;
  logic [31:0]     ra [NREQ];
  logic [31:0]     rb [NREQ];
  logic            rsp_rdy = 1'b1;
  assign bus.req_valid = rv;
  assign bus.rsp_ready = rsp_rdy;
  for (genvar i = 0; i < NREQ; i++) begin : g_pack
    assign bus.req_a[32*i +: 32] = ra[i];
    assign bus.req_b[32*i +: 32] = rb[i];
  end

  typedef struct {
    int              id;
    logic [31:0]     a;
    logic [31:0]     b;
    logic [NREQ-1:0] mask;
    int              cyc;
  } grant_t;
  typedef struct {
    int          id;
    logic [31:0] res;
    logic        err;
    int          cyc;
  } rsp_t;

  grant_t gq[$];
  rsp_t   rq[$];
  int     rsq[$];
  int     total = 0, bad = 0;
  int     cyc = 0, n_multi = 0, run_cycles = 0, mptr = 0;
  logic   prev_crst = 1'b0;

  function automatic logic [31:0] ref_gcd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic int ref_pick(input logic [NREQ-1:0] mask, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (ptr + k) % NREQ;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  // One clock: record grants/responses at negedge, retire granted requests after the edge.
  task automatic tick();
    logic [NREQ-1:0] gmask;
    @(negedge clk);
    cyc++;
    gmask = rst_n ? bus.req_ready : '0;
    if (gmask != 0) begin
      if ($countones(gmask) != 1) n_multi++;
      for (int i = 0; i < NREQ; i++)
        if (gmask[i]) gq.push_back('{i, ra[i], rb[i], rv, cyc});
    end
    if (rst_n && bus.rsp_valid && rsp_rdy)
      rq.push_back('{int'(bus.rsp_id), bus.rsp_result, bus.rsp_err, cyc});
    if (core_rst_n) begin
      run_cycles++;
      if (!prev_crst) rsq.push_back(cyc);
    end
    prev_crst = core_rst_n;
    @(posedge clk);
    #1;
    rv = rv & ~gmask;
  endtask

  task automatic clear_q();
    gq.delete();
    rq.delete();
    rsq.delete();
    n_multi    = 0;
    run_cycles = 0;
  endtask

  task automatic do_reset();
    rv      = '0;
    rsp_rdy = 1'b1;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    mptr      = 0;
    prev_crst = 1'b0;
    clear_q();
  endtask

  task automatic test_reset();
    #1;
    for (int i = 0; i < NREQ; i++) begin ra[i] = 32'd5 + i; rb[i] = 32'd10; end
    rv    = '1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.req_ready !== '0) begin bad++; $display("FAIL rst_req_ready: got %b want 0", bus.req_ready); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); end
    total++; if (bus.rsp_id !== '0) begin bad++; $display("FAIL rst_rsp_id: got %0d want 0", bus.rsp_id); end
    total++; if (bus.rsp_result !== 32'd0) begin bad++; $display("FAIL rst_rsp_result: got %0d want 0", bus.rsp_result); end
    total++; if (bus.rsp_err !== 1'b0) begin bad++; $display("FAIL rst_rsp_err: got %b want 0", bus.rsp_err); end
    total++; if (core_ina !== 32'd0 || core_inb !== 32'd0) begin bad++; $display("FAIL rst_core_in: got %0d/%0d want 0/0", core_ina, core_inb); end
    total++; if (core_rst_n !== 1'b0) begin bad++; $display("FAIL rst_core_rst_n: got %b want 0", core_rst_n); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    rv = '0;
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    ra[0] = 32'd12; rb[0] = 32'd18; rv = 4'b0001;
    for (int c = 0; c < 300 && rq.size() < 1; c++) tick();
    tick();
    total++; if (rq.size() != 1) begin bad++; $display("FAIL basic_rsp_count: got %0d want 1", rq.size()); end
    total++; if (gq.size() != 1) begin bad++; $display("FAIL basic_grant_pulses: got %0d want 1", gq.size()); end
    if (gq.size() >= 1 && rq.size() >= 1 && rsq.size() >= 1) begin
      total++; if (gq[0].id != 0) begin bad++; $display("FAIL basic_grant_id: got %0d want 0", gq[0].id); end
      total++; if (rq[0].id != 0) begin bad++; $display("FAIL basic_rsp_id: got %0d want 0", rq[0].id); end
      total++; if (rq[0].res !== 32'd6) begin bad++; $display("FAIL basic_result: got %0d want 6", rq[0].res); end
      total++; if (rq[0].err !== 1'b0) begin bad++; $display("FAIL basic_err: got %b want 0", rq[0].err); end
      total++; if (rsq[0] - gq[0].cyc != 1 + LOAD_CYC) begin bad++; $display("FAIL basic_run_latency: got %0d want %0d", rsq[0] - gq[0].cyc, 1 + LOAD_CYC); end
    end
    total++; if (busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL basic_idle_after: got busy=%b valid=%b want 0/0", busy, bus.rsp_valid); end
    mptr = 1;
  endtask

  task automatic test_all_four();
    do_reset();
    for (int i = 0; i < NREQ; i++) begin ra[i] = 32'd35; rb[i] = 32'd21; end
    rv = '1;
    for (int c = 0; c < 800 && rq.size() < NREQ; c++) tick();
    total++; if (rq.size() != NREQ || gq.size() != NREQ) begin bad++; $display("FAIL four_counts: got grants=%0d rsps=%0d want %0d", gq.size(), rq.size(), NREQ); end
    for (int k = 0; k < NREQ && k < rq.size() && k < gq.size(); k++) begin
      int exp_id;
      exp_id = ref_pick(gq[k].mask, mptr);
      mptr   = (exp_id + 1) % NREQ;
      total++; if (gq[k].id != exp_id || exp_id != k) begin bad++; $display("FAIL four_grant_order[%0d]: got %0d want %0d", k, gq[k].id, k); end
      total++; if (rq[k].id != exp_id || rq[k].res !== 32'd7 || rq[k].err !== 1'b0) begin bad++; $display("FAIL four_rsp[%0d]: got id=%0d res=%0d err=%b want id=%0d res=7 err=0", k, rq[k].id, rq[k].res, rq[k].err, exp_id); end
    end
  endtask

  task automatic test_rr_order();
    clear_q();
    ra[2] = 32'd100; rb[2] = 32'd75; rv = 4'b0100;
    for (int c = 0; c < 300 && rq.size() < 1; c++) tick();
    ra[1] = 32'd14; rb[1] = 32'd49; ra[3] = 32'd27; rb[3] = 32'd36;
    rv = 4'b1010;
    for (int c = 0; c < 600 && rq.size() < 3; c++) tick();
    total++; if (rq.size() != 3 || gq.size() != 3) begin bad++; $display("FAIL rr_counts: got grants=%0d rsps=%0d want 3", gq.size(), rq.size()); end
    for (int k = 0; k < 3 && k < rq.size() && k < gq.size(); k++) begin
      int exp_id;
      exp_id = ref_pick(gq[k].mask, mptr);
      mptr   = (exp_id + 1) % NREQ;
      total++; if (rq[k].id != exp_id) begin bad++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, rq[k].id, exp_id); end
      total++; if (rq[k].res !== ref_gcd(gq[k].a, gq[k].b)) begin bad++; $display("FAIL rr_result[%0d]: got %0d want %0d", k, rq[k].res, ref_gcd(gq[k].a, gq[k].b)); end
    end
  endtask

  task automatic test_backpressure();
    int seen;
    int exp_id;
    clear_q();
    ra[1] = 32'd48; rb[1] = 32'd180; rsp_rdy = 1'b0; rv = 4'b0010;
    exp_id = ref_pick(4'b0010, mptr);
    mptr   = (exp_id + 1) % NREQ;
    seen   = 0;
    for (int c = 0; c < 300 && !seen; c++) begin
      tick();
      seen = bus.rsp_valid ? 1 : 0;
    end
    total++; if (!seen) begin bad++; $display("FAIL bp_rsp_timeout: got no rsp_valid want rsp_valid within 300 cycles"); end
    for (int c = 0; c < 5; c++) begin
      tick();
      total++; if (bus.rsp_valid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL bp_hold_valid[%0d]: got valid=%b busy=%b want 1/1", c, bus.rsp_valid, busy); end
      total++; if (int'(bus.rsp_id) != exp_id || bus.rsp_result !== 32'd12 || bus.rsp_err !== 1'b0) begin bad++; $display("FAIL bp_hold_data[%0d]: got id=%0d res=%0d err=%b want id=%0d res=12 err=0", c, bus.rsp_id, bus.rsp_result, bus.rsp_err, exp_id); end
    end
    rsp_rdy = 1'b1;
    tick();
    total++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL bp_release: got valid=%b busy=%b want 0/0", bus.rsp_valid, busy); end
    total++; if (rq.size() != 1) begin bad++; $display("FAIL bp_rsp_count: got %0d want 1", rq.size()); end
  endtask

  task automatic test_edge_operands();
    logic [31:0] ea [6] = '{32'd0, 32'd17, 32'd0, 32'd7, 32'hFFFF_FFFF, 32'd1071};
    logic [31:0] eb [6] = '{32'd7, 32'd13, 32'd0, 32'd0, 32'hFFFF_FFFE, 32'd462};
    logic [31:0] ee [6] = '{32'd7, 32'd1, 32'd0, 32'd7, 32'd1, 32'd21};
    for (int t = 0; t < 6; t++) begin
      int r;
      clear_q();
      r = t % NREQ;
      ra[r] = ea[t]; rb[r] = eb[t];
      rv[r] = 1'b1;
      for (int c = 0; c < 300 && rq.size() < 1; c++) tick();
      mptr = (r + 1) % NREQ;
      total++;
      if (rq.size() != 1) begin
        bad++; $display("FAIL edge_timeout[%0d]: got %0d responses want 1", t, rq.size());
      end else if (rq[0].res !== ee[t] || rq[0].id != r) begin
        bad++; $display("FAIL edge_result[%0d]: got id=%0d res=%0d want id=%0d res=%0d", t, rq[0].id, rq[0].res, r, ee[t]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    clear_q();
    ra[0] = 32'd1_000_000_007; rb[0] = 32'd998_244_353; rv = 4'b0001;
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      tick();
      seen = core_rst_n ? 1 : 0;
    end
    total++; if (!seen) begin bad++; $display("FAIL midrst_no_run: got core_rst_n=%b want 1", core_rst_n); end
    rv[2] = 1'b1; ra[2] = 32'd4; rb[2] = 32'd6;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (core_rst_n !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL midrst_ctrl: got core_rst_n=%b busy=%b want 0/0", core_rst_n, busy); end
    total++; if (bus.req_ready !== '0 || bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL midrst_hs: got req_ready=%b rsp_valid=%b want 0/0", bus.req_ready, bus.rsp_valid); end
    total++; if (core_ina !== 32'd0 || core_inb !== 32'd0 || bus.rsp_result !== 32'd0 || bus.rsp_id !== '0) begin bad++; $display("FAIL midrst_data: got ina=%0d inb=%0d res=%0d id=%0d want 0", core_ina, core_inb, bus.rsp_result, bus.rsp_id); end
    rv = '0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    mptr      = 0;
    prev_crst = 1'b0;
    clear_q();
    repeat (3) tick();
    ra[3] = 32'd9; rb[3] = 32'd6; rv = 4'b1000;
    for (int c = 0; c < 300 && rq.size() < 1; c++) tick();
    repeat (5) tick();
    total++; if (rq.size() != 1) begin bad++; $display("FAIL midrst_rsp_count: got %0d want 1", rq.size()); end
    if (rq.size() >= 1) begin
      total++; if (rq[0].id != 3 || rq[0].res !== 32'd3) begin bad++; $display("FAIL midrst_after: got id=%0d res=%0d want id=3 res=3", rq[0].id, rq[0].res); end
    end
    mptr = 0;
  endtask

  task automatic test_random();
    int issued;
    int n_tx;
    n_tx   = 40;
    issued = 0;
    clear_q();
    for (int c = 0; c < 20000 && rq.size() < n_tx; c++) begin
      tick();
      rsp_rdy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!rv[i] && issued < n_tx && $urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 3))
            0: begin ra[i] = $urandom_range(0, 100); rb[i] = $urandom_range(0, 100); end
            1: begin
              logic [31:0] g;
              g = $urandom_range(1, 1000);
              ra[i] = g * $urandom_range(1, 5000);
              rb[i] = g * $urandom_range(1, 5000);
            end
            2: begin ra[i] = $urandom; rb[i] = $urandom; end
            default: begin ra[i] = 32'd0; rb[i] = $urandom_range(1, 1 << 20); end
          endcase
          rv[i] = 1'b1;
          issued++;
        end
      end
    end
    rsp_rdy = 1'b1;
    total++; if (rq.size() != n_tx || gq.size() != n_tx) begin bad++; $display("FAIL rand_counts: got grants=%0d rsps=%0d want %0d", gq.size(), rq.size(), n_tx); end
    total++; if (n_multi != 0) begin bad++; $display("FAIL rand_onehot: got %0d multi-hot grants want 0", n_multi); end
    for (int k = 0; k < n_tx && k < rq.size() && k < gq.size(); k++) begin
      int exp_id;
      exp_id = ref_pick(gq[k].mask, mptr);
      mptr   = (exp_id + 1) % NREQ;
      total++; if (gq[k].id != exp_id || rq[k].id != exp_id) begin bad++; $display("FAIL rand_id[%0d]: got grant=%0d rsp=%0d want %0d", k, gq[k].id, rq[k].id, exp_id); end
      total++; if (rq[k].res !== ref_gcd(gq[k].a, gq[k].b) || rq[k].err !== 1'b0) begin bad++; $display("FAIL rand_result[%0d]: got res=%0d err=%b want res=%0d err=0 (a=%0d b=%0d)", k, rq[k].res, rq[k].err, ref_gcd(gq[k].a, gq[k].b), gq[k].a, gq[k].b); end
    end
  endtask

`ifdef GCD_ARB_TIMEOUT_EN
  task automatic test_timeout();
    repeat (2) tick();
    clear_q();
    stub_hang = 1'b1;
    ra[0] = 32'd9; rb[0] = 32'd6; rv = 4'b0001;
    for (int c = 0; c < 600 && rq.size() < 1; c++) tick();
    total++; if (rq.size() != 1) begin bad++; $display("FAIL timeout_no_rsp: got %0d responses want 1", rq.size()); end
    if (rq.size() >= 1) begin
      total++; if (rq[0].err !== 1'b1 || rq[0].res !== 32'd0) begin bad++; $display("FAIL timeout_rsp: got err=%b res=%0d want err=1 res=0", rq[0].err, rq[0].res); end
    end
    total++; if (run_cycles != TIMEOUT) begin bad++; $display("FAIL timeout_run_cycles: got %0d want %0d", run_cycles, TIMEOUT); end
    stub_hang = 1'b0;
    tick();
    mptr = 1;
  endtask
`endif

  initial begin
    for (int i = 0; i < NREQ; i++) begin ra[i] = '0; rb[i] = '0; end
    test_reset();
    test_basic();
    test_all_four();
    test_rr_order();
    test_backpressure();
    test_edge_operands();
    test_reset_mid_run();
    test_random();
`ifdef GCD_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end
endmodule
